mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares one single-port memory bus between the CPU instruction-fetch port and data port.
//   - Multi-cycle FSM holds the bus for a fixed wait-state count, then returns a one-cycle ack.
//   - Default policy: data port has priority, with a starvation guard for fetch.
//   - Sits between the cpu core and the external memory (ADDR / Data_BUS_* / CS / wr_rd).
// PARAMETERS
//   ADDR_W        32  address width, both ports and memory side
//   DATA_W        32  data width
//   WAIT_CYCLES    2  cycles mem_cs is held per access; legal range >=1
//   STARVE_LIMIT   4  consecutive data grants while if_req is pending before fetch is forced; >=1
// PORTS
//   CLK        in   1       system clock, all logic on posedge
//   reset      in   1       synchronous, active-low
//   if_req     in   1       fetch request, held high until if_ack
//   if_addr    in   ADDR_W  fetch address
//   if_rdata   out  DATA_W  fetched word, valid with if_ack, held until next if_ack
//   if_ack     out  1       one-cycle fetch completion pulse
//   dm_req     in   1       data request, held high until dm_ack
//   dm_wr_rd   in   1       1=write, 0=read
//   dm_addr    in   ADDR_W  data address
//   dm_wdata   in   DATA_W  write data
//   dm_rdata   out  DATA_W  read data, valid with dm_ack, held until next dm_ack
//   dm_ack     out  1       one-cycle data completion pulse
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data, valid in the last cycle of mem_cs
//   mem_cs     out  1       memory chip select
//   mem_wr_rd  out  1       1=write, 0=read
//   busy       out  1       high in ACCESS or ACK
//   grant_dm   out  1       owner of the current/last access: 1=data port, 0=fetch
// BEHAVIOUR
//   Reset (reset==0 at posedge):
//   - State IDLE; wait counter and starve counter cleared.
//   - All outputs 0: acks, mem_cs, mem_wr_rd, busy, grant_dm, mem_addr, mem_wdata, both rdata regs.
//   FSM states: IDLE, ACCESS, ACK.
//   IDLE
//   - Arbitrates on the current cycle's requests.
//   - dm_req wins, unless starve_cnt==STARVE_LIMIT and if_req is high; then fetch wins.
//   - On a win, at the edge:
//     - Latch the winner's addr, wdata and wr_rd onto the mem_* outputs.
//     - Set grant_dm; load wait_cnt = WAIT_CYCLES-1; go to ACCESS.
//   - No request: stay in IDLE.
//   ACCESS
//   - mem_cs=1 and busy=1; mem_* outputs are stable for the whole phase.
//   - wait_cnt decrements each cycle.
//   - When wait_cnt==0: capture mem_rdata into the owner's rdata reg (reads only; writes leave it unchanged); go to ACK.
//   ACK
//   - Owner's ack=1 for exactly one cycle; mem_cs=0, mem_wr_rd=0; go to IDLE.
//   - No arbitration in ACK. A requester samples ack at the edge and deasserts req from that edge on.
//   Latency
//   - req seen in IDLE at cycle 0; mem_cs high cycles 1..WAIT_CYCLES; ack at cycle WAIT_CYCLES+1.
//   - Minimum spacing between grants: WAIT_CYCLES+2 cycles.
//   Starve counter
//   - +1 on each data grant made while if_req is high; saturates at STARVE_LIMIT.
//   - Cleared on any fetch grant.
//   Simultaneous if_req and dm_req with starve_cnt < STARVE_LIMIT: data granted; fetch waits.
//   Request dropped mid-ACCESS: protocol violation. The access still completes and the ack is still issued.
//   Request inputs change during ACCESS: ignored (values were latched at grant).
//   Reset mid-access: forces IDLE immediately; no ack is issued for the aborted access.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN defined:
//   - Starve counter is removed.
//   - A 1-bit last-owner flag gives priority to the port not granted last when both request.
//   - A single requester is always granted.
//   - Flag resets to "last=data", so fetch wins the first tie.
//   ARB_ROUND_ROBIN_EN undefined: data priority with the STARVE_LIMIT guard, as above.
// TESTING
//   1. Fetch read, WAIT_CYCLES=2: if_req=1, if_addr=0x40, mem_rdata=0x18CF
//      -> mem_cs high cycles 1-2, mem_addr=0x40, if_ack at cycle 3, if_rdata=0x18CF.
//   2. Data write: dm_req=1, dm_wr_rd=1, dm_addr=0x100, dm_wdata=0x21CF
//      -> mem_wr_rd=1 and mem_wdata=0x21CF for 2 cycles, dm_ack=1, dm_rdata unchanged.
//   3. Both requesting at cycle 0 -> data granted first (dm_ack cycle 3); fetch granted at cycle 4 (if_ack cycle 7).
//   4. dm_req held continuously and if_req held continuously
//      -> 4 data grants, then 1 fetch grant; pattern repeats (default build).
//   5. reset=0 during the 2nd ACCESS cycle
//      -> next cycle mem_cs=0, no ack ever, busy=0; a new request after release completes normally.
//   6. ARB_ROUND_ROBIN_EN defined, both requesting continuously
//      -> grants alternate F,D,F,D; acks spaced 4 cycles apart.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the external memory.
// The arbiter uses the slave modport; the CPU/memory side (or a bench) uses master.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_wr_rd;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_cs;
    logic              mem_wr_rd;

    logic              busy;
    logic              grant_dm;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr_rd, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_addr, mem_wdata, mem_cs, mem_wr_rd, busy, grant_dm
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr_rd, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_addr, mem_wdata, mem_cs, mem_wr_rd, busy, grant_dm
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between CPU fetch and data ports with fixed wait states.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data priority with a fetch starvation guard.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              w_grantValid;
    logic              w_grantDm;

    logic [WCW-1:0]    r_waitCnt;
    logic              r_grantDm;
    logic              r_memWrRd;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_dmRdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_lastDm;
`else
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
    logic [SCW-1:0] r_starveCnt;
`endif

    always_comb begin
        w_nextState  = r_state;
        w_grantValid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        // On a tie the port that did not own the last access wins.
        w_grantDm    = bus.dm_req && (!bus.if_req || !r_lastDm);
`else
        w_grantDm    = bus.dm_req && !(bus.if_req && (r_starveCnt == STARVE_MAX));
`endif
        case (r_state)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    w_grantValid = 1'b1;
                    w_nextState  = ACCESS;
                end
            end
            ACCESS: begin
                if (r_waitCnt == '0) begin
                    w_nextState = ACK;
                end
            end
            ACK: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_waitCnt  <= '0;
            r_grantDm  <= 1'b0;
            r_memWrRd  <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_ifRdata  <= '0;
            r_dmRdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_lastDm   <= 1'b1;
`else
            r_starveCnt <= '0;
`endif
        end else begin
            r_state <= w_nextState;
            if (w_grantValid) begin
                r_grantDm  <= w_grantDm;
                r_memAddr  <= w_grantDm ? bus.dm_addr : bus.if_addr;
                r_memWdata <= w_grantDm ? bus.dm_wdata : '0;
                r_memWrRd  <= w_grantDm && bus.dm_wr_rd;
                r_waitCnt  <= WAIT_LOAD;
`ifdef ARB_ROUND_ROBIN_EN
                r_lastDm   <= w_grantDm;
`else
                if (!w_grantDm) begin
                    r_starveCnt <= '0;
                end else if (bus.if_req && (r_starveCnt != STARVE_MAX)) begin
                    r_starveCnt <= r_starveCnt + 1'b1;
                end
`endif
            end
            // Read data is sampled in the final chip-select cycle only.
            if (r_state == ACCESS) begin
                if (r_waitCnt != '0) begin
                    r_waitCnt <= r_waitCnt - 1'b1;
                end else if (!r_memWrRd) begin
                    if (r_grantDm) begin
                        r_dmRdata <= bus.mem_rdata;
                    end else begin
                        r_ifRdata <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.mem_cs    = (r_state == ACCESS);
    assign bus.mem_wr_rd = r_memWrRd && (r_state == ACCESS);
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.busy      = (r_state != IDLE);
    assign bus.grant_dm  = r_grantDm;
    assign bus.if_ack    = (r_state == ACK) && !r_grantDm;
    assign bus.dm_ack    = (r_state == ACK) && r_grantDm;
    assign bus.if_rdata  = r_ifRdata;
    assign bus.dm_rdata  = r_dmRdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (WAIT_CYCLES=2, STARVE_LIMIT=4).
// Expectations for the rotation test follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_bus_arbiter;

    logic CLK;
    logic reset;
    int   vectors;
    int   miscompares;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2), .STARVE_LIMIT(4)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic dmReq, input logic dmWrRd,
                                 input logic [31:0] dmAddr, input logic [31:0] dmWdata);
        bus.if_req   = ifReq;
        bus.if_addr  = ifAddr;
        bus.dm_req   = dmReq;
        bus.dm_wr_rd = dmWrRd;
        bus.dm_addr  = dmAddr;
        bus.dm_wdata = dmWdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        logic firstDm;
        logic expOwner [10];
        logic ackOwner [10];
        int   ackCycle [10];
        int   nAcks;
        int   cyc;

        vectors     = 0;
        miscompares = 0;
        if (RR) expOwner = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        else    expOwner = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_rdata = 32'h0;
        stepCycle();
        stepCycle();
        checkBit("rst_mem_cs", bus.mem_cs, 1'b0);
        checkBit("rst_mem_wr_rd", bus.mem_wr_rd, 1'b0);
        checkBit("rst_busy", bus.busy, 1'b0);
        checkBit("rst_grant_dm", bus.grant_dm, 1'b0);
        checkBit("rst_if_ack", bus.if_ack, 1'b0);
        checkBit("rst_dm_ack", bus.dm_ack, 1'b0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
        checkOutput("rst_if_rdata", bus.if_rdata, 32'h0);
        checkOutput("rst_dm_rdata", bus.dm_rdata, 32'h0);
        reset = 1'b1;
        stepCycle();

        // Test 1: fetch read
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_rdata = 32'h18CF;
        stepCycle();
        checkBit("t1_c1_mem_cs", bus.mem_cs, 1'b1);
        checkBit("t1_c1_busy", bus.busy, 1'b1);
        checkBit("t1_c1_grant_dm", bus.grant_dm, 1'b0);
        checkBit("t1_c1_mem_wr_rd", bus.mem_wr_rd, 1'b0);
        checkOutput("t1_c1_mem_addr", bus.mem_addr, 32'h40);
        stepCycle();
        checkBit("t1_c2_mem_cs", bus.mem_cs, 1'b1);
        checkBit("t1_c2_if_ack", bus.if_ack, 1'b0);
        stepCycle();
        checkBit("t1_c3_if_ack", bus.if_ack, 1'b1);
        checkBit("t1_c3_mem_cs", bus.mem_cs, 1'b0);
        checkBit("t1_c3_busy", bus.busy, 1'b1);
        checkOutput("t1_c3_if_rdata", bus.if_rdata, 32'h18CF);
        bus.if_req = 1'b0;
        stepCycle();
        checkBit("t1_c4_if_ack", bus.if_ack, 1'b0);
        checkBit("t1_c4_busy", bus.busy, 1'b0);
        checkOutput("t1_c4_if_rdata_held", bus.if_rdata, 32'h18CF);

        // Test 2: data write leaves dm_rdata unchanged
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h21CF);
        bus.mem_rdata = 32'hDEAD;
        stepCycle();
        checkBit("t2_c1_mem_wr_rd", bus.mem_wr_rd, 1'b1);
        checkBit("t2_c1_grant_dm", bus.grant_dm, 1'b1);
        checkOutput("t2_c1_mem_addr", bus.mem_addr, 32'h100);
        checkOutput("t2_c1_mem_wdata", bus.mem_wdata, 32'h21CF);
        stepCycle();
        checkBit("t2_c2_mem_wr_rd", bus.mem_wr_rd, 1'b1);
        checkBit("t2_c2_mem_cs", bus.mem_cs, 1'b1);
        stepCycle();
        checkBit("t2_c3_dm_ack", bus.dm_ack, 1'b1);
        checkBit("t2_c3_if_ack", bus.if_ack, 1'b0);
        checkBit("t2_c3_mem_wr_rd", bus.mem_wr_rd, 1'b0);
        checkOutput("t2_c3_dm_rdata", bus.dm_rdata, 32'h0);
        bus.dm_req = 1'b0;
        stepCycle();
        checkBit("t2_c4_busy", bus.busy, 1'b0);

        // Test 3: simultaneous requests; data first unless round-robin gives fetch the turn
        firstDm = !RR;
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h200, 32'h0);
        bus.mem_rdata = 32'h1111;
        stepCycle();
        checkBit("t3_c1_grant_dm", bus.grant_dm, firstDm);
        checkOutput("t3_c1_mem_addr", bus.mem_addr, firstDm ? 32'h200 : 32'h44);
        bus.mem_rdata = 32'h2222;
        stepCycle();
        checkBit("t3_c2_mem_cs", bus.mem_cs, 1'b1);
        stepCycle();
        checkBit("t3_c3_first_ack", firstDm ? bus.dm_ack : bus.if_ack, 1'b1);
        checkBit("t3_c3_other_ack", firstDm ? bus.if_ack : bus.dm_ack, 1'b0);
        checkOutput("t3_c3_first_rdata", firstDm ? bus.dm_rdata : bus.if_rdata, 32'h2222);
        if (firstDm) bus.dm_req = 1'b0;
        else         bus.if_req = 1'b0;
        stepCycle();
        checkBit("t3_c4_busy", bus.busy, 1'b0);
        bus.mem_rdata = 32'h3333;
        stepCycle();
        checkBit("t3_c5_grant_dm", bus.grant_dm, !firstDm);
        checkOutput("t3_c5_mem_addr", bus.mem_addr, firstDm ? 32'h44 : 32'h200);
        stepCycle();
        stepCycle();
        checkBit("t3_c7_second_ack", firstDm ? bus.if_ack : bus.dm_ack, 1'b1);
        checkOutput("t3_c7_second_rdata", firstDm ? bus.if_rdata : bus.dm_rdata, 32'h3333);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        stepCycle();
        checkBit("t3_c8_busy", bus.busy, 1'b0);

        // Test 4: both held continuously, record ack order and spacing
        applyStimulus(1'b1, 32'h48, 1'b1, 1'b0, 32'h400, 32'h0);
        nAcks = 0;
        cyc   = 0;
        while (nAcks < 10 && cyc < 80) begin
            stepCycle();
            cyc++;
            if (bus.dm_ack || bus.if_ack) begin
                ackOwner[nAcks] = bus.dm_ack;
                ackCycle[nAcks] = cyc;
                nAcks++;
                if (nAcks == 10) begin
                    bus.if_req = 1'b0;
                    bus.dm_req = 1'b0;
                end
            end
        end
        checkOutput("t4_ack_count", nAcks, 10);
        for (int i = 0; i < nAcks; i++) begin
            checkBit($sformatf("t4_owner%0d", i), ackOwner[i], expOwner[i]);
            if (i == 0) checkOutput("t4_first_ack_cycle", ackCycle[0], 3);
            else        checkOutput($sformatf("t4_spacing%0d", i), ackCycle[i] - ackCycle[i-1], 4);
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        stepCycle();
        checkBit("t4_idle_busy", bus.busy, 1'b0);

        // Test 5: reset during the second ACCESS cycle aborts without an ack
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
        bus.mem_rdata = 32'h7777;
        stepCycle();
        stepCycle();
        checkBit("t5_c2_mem_cs", bus.mem_cs, 1'b1);
        reset      = 1'b0;
        bus.dm_req = 1'b0;
        stepCycle();
        checkBit("t5_rst_mem_cs", bus.mem_cs, 1'b0);
        checkBit("t5_rst_busy", bus.busy, 1'b0);
        checkBit("t5_rst_dm_ack", bus.dm_ack, 1'b0);
        checkOutput("t5_rst_dm_rdata", bus.dm_rdata, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkBit($sformatf("t5_no_ack%0d", i), bus.dm_ack | bus.if_ack, 1'b0);
        end
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_rdata = 32'h5A5A;
        cyc = 0;
        while (!bus.if_ack && cyc < 20) begin
            stepCycle();
            cyc++;
        end
        checkOutput("t5_post_ack_latency", cyc, 3);
        checkOutput("t5_post_if_rdata", bus.if_rdata, 32'h5A5A);
        bus.if_req = 1'b0;
        stepCycle();
        checkBit("t5_final_busy", bus.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
